pwm_dac: RTL and testbench

Digital-to-analog output stage for the mixed-signal test chip, the reverse direction of the 4-bit SAR conversion path. It accepts digital codes over a valid/ready handshake and buffers them in a small FIFO. Each code is reproduced as a pulse-width-modulated stream, with duty cycle equal to code / 2^WIDTH. The pwm_out pin drives an external RC reconstruction filter, and that filter's output can be looped back to the ADC comparator input.

---
 rtl/pwm_dac.sv | 121 ++++++++++++
 tb/tb_pwm_dac.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// PWM output stage: codes arrive over valid/ready into a small FIFO and are
// reproduced as pulse-width-modulated frames of 2^WIDTH cycles each.
module pwm_dac #(
  parameter int WIDTH       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 1
) (
  input  logic                             clk,
  input  logic                             rstp,
  input  logic [WIDTH-1:0]                 din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic                             pwm_out,
  output logic                             frame_start,
  output logic                             underrun,
  output logic [WIDTH-1:0]                 level,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             state_dbg
);

  // Handshake: a code transfers at a rising edge where din_valid && din_ready.
  // din_ready depends only on the registered FIFO occupancy, never on a pop
  // happening in the same cycle.

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [WIDTH-1:0] CNT_LAST  = '1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_FRAMES - 1);
  localparam logic [CW-1:0]    FULL      = CW'(FIFO_DEPTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_cnt;
  logic [HW-1:0]    r_hold;
  logic [WIDTH-1:0] r_level;
  logic             r_underrun;

  logic w_ready;
  logic w_push;
  logic w_not_empty;
  logic w_frame_end;
  logic w_reload;
  logic w_pop;

  assign w_ready     = (r_count < FULL);
  assign w_push      = din_valid && w_ready;
  assign w_not_empty = (r_count != '0);
  assign w_frame_end = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  // IDLE takes a code as soon as one exists; RUN only after the last held frame.
  assign w_reload    = (r_state == S_IDLE) || (w_frame_end && (r_hold == HOLD_LAST));
  assign w_pop       = w_reload && w_not_empty;

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_level    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_not_empty) begin
            r_state <= S_RUN;
            r_level <= r_mem[r_rptr];
            r_cnt   <= '0;
            r_hold  <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_frame_end) begin
            if (r_hold != HOLD_LAST) begin
              r_hold <= r_hold + 1'b1;
            end else begin
              r_hold <= '0;
              if (w_not_empty) r_level <= r_mem[r_rptr];
              else             r_underrun <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign din_ready   = w_ready;
  assign pwm_out     = (r_state == S_RUN) && (r_cnt < r_level);
  assign frame_start = (r_state == S_RUN) && (r_cnt == '0);
  assign underrun    = r_underrun;
  assign level       = r_level;
  assign fifo_count  = r_count;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: one instance with default parameters and one
// with HOLD_FRAMES = 2, both sharing clock and reset.
module tb_pwm_dac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstp;
  logic [3:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       ready_a, pwm_a, fs_a, ur_a, st_a;
  logic       ready_b, pwm_b, fs_b, ur_b, st_b;
  logic [3:0] lvl_a, lvl_b;
  logic [2:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  pwm_dac u_dut_a (
    .clk(clk), .rstp(rstp), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
    .pwm_out(pwm_a), .frame_start(fs_a), .underrun(ur_a), .level(lvl_a),
    .fifo_count(cnt_a), .state_dbg(st_a)
  );

  pwm_dac #(.HOLD_FRAMES(2)) u_dut_b (
    .clk(clk), .rstp(rstp), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
    .pwm_out(pwm_b), .frame_start(fs_b), .underrun(ur_b), .level(lvl_b),
    .fifo_count(cnt_b), .state_dbg(st_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit sel, input logic [3:0] code);
    if (sel) begin din_b = code; valid_b = 1'b1; end
    else     begin din_a = code; valid_a = 1'b1; end
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  // One cycle of a frame at counter position i, then advance the clock.
  task automatic cyc(input bit sel, input int i, input int code, input bit ur);
    logic       p, f, u;
    logic [3:0] l;
    p = sel ? pwm_b : pwm_a;
    f = sel ? fs_b  : fs_a;
    u = sel ? ur_b  : ur_a;
    l = sel ? lvl_b : lvl_a;
    check($sformatf("pwm[%0d] code %0d", i, code), p, (i < code));
    check($sformatf("frame_start[%0d]", i), f, (i == 0));
    check($sformatf("underrun[%0d]", i), u, ((i == 0) && ur));
    check($sformatf("level[%0d]", i), l, code);
    tick();
  endtask

  task automatic frame(input bit sel, input int code, input bit ur);
    for (int i = 0; i < 16; i++) cyc(sel, i, code, ur);
  endtask

  task automatic do_reset;
    rstp = 1'b1;
    #2;
    check("rst pwm_a", pwm_a, 0);
    check("rst fs_a", fs_a, 0);
    check("rst ur_a", ur_a, 0);
    check("rst level_a", lvl_a, 0);
    check("rst count_a", cnt_a, 0);
    check("rst ready_a", ready_a, 1);
    check("rst state_a", st_a, 0);
    check("rst pwm_b", pwm_b, 0);
    check("rst count_b", cnt_b, 0);
    check("rst ready_b", ready_b, 1);
    check("rst state_b", st_b, 0);
    tick();
    tick();
    rstp = 1'b0;
    tick();
    check("post-rst state_a", st_a, 0);
    check("post-rst pwm_a", pwm_a, 0);
    check("post-rst count_a", cnt_a, 0);
  endtask

  logic [3:0] codes [6];
  int         k;
  bit         exp_ready;
  int         exp_cnt;

  initial begin
    rstp    = 1'b0;
    din_a   = '0;
    din_b   = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    #1;
    do_reset();

    // Reset mid-run with three codes queued: queue must be flushed.
    push(0, 4'd9);
    push(0, 4'd2);
    push(0, 4'd3);
    push(0, 4'd4);
    check("midrun count", cnt_a, 3);
    check("midrun state", st_a, 1);
    check("midrun level", lvl_a, 9);
    check("midrun pwm", pwm_a, 1);
    do_reset();
    repeat (3) tick();
    check("flushed state", st_a, 0);
    check("flushed pwm", pwm_a, 0);
    check("flushed count", cnt_a, 0);

    // Single code 5: latency, duty, underrun on later boundaries.
    push(0, 4'd5);
    check("lat count", cnt_a, 1);
    check("lat state", st_a, 0);
    check("lat fs", fs_a, 0);
    tick();
    frame(0, 5, 0);
    frame(0, 5, 1);
    do_reset();

    // Boundary codes 0 and 15.
    push(0, 4'd0);
    push(0, 4'd15);
    check("bnd count", cnt_a, 1);
    frame(0, 0, 0);
    frame(0, 15, 0);
    frame(0, 15, 1);
    do_reset();

    // Underrun with code 9 over three extra frames.
    push(0, 4'd9);
    tick();
    frame(0, 9, 0);
    repeat (3) frame(0, 9, 1);
    do_reset();

    // Backpressure: six codes with valid held high while running.
    codes = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    push(0, 4'd1);
    tick();
    k       = 0;
    din_a   = codes[0];
    valid_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        exp_ready = (f == 0) ? (i < 4) : (i == 0);
        exp_cnt   = (f == 0) ? ((i < 4) ? i : 4) : ((i == 0) ? 3 : 4);
        check($sformatf("bp ready f%0d c%0d", f, i), ready_a, exp_ready);
        check($sformatf("bp count f%0d c%0d", f, i), cnt_a, exp_cnt);
        cyc(0, i, f + 1, 0);
        if (exp_ready) begin
          k++;
          if (k == 6) valid_a = 1'b0;
          else        din_a   = codes[k];
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      check($sformatf("drain count f%0d", f), cnt_a, 3 - f);
      frame(0, 4 + f, 0);
    end
    frame(0, 7, 1);
    do_reset();

    // HOLD_FRAMES = 2 instance: each code spans two frames.
    push(1, 4'd3);
    push(1, 4'd12);
    check("hold count", cnt_b, 1);
    frame(1, 3, 0);
    frame(1, 3, 0);
    frame(1, 12, 0);
    frame(1, 12, 0);
    frame(1, 12, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
